// File: rtl/vip_bin_morph_3x3_pkg.sv
// Shared definitions for the 3x3 binary morphology stage and its helpers.
//   - morph_mode_e : operation select encodings
//   - MORPH_LATENCY: clocks from window input to filtered output
//   - FG_COUNT_W   : width of the per-frame foreground counter
//   - POS_W        : width of the column/row position counters
package vip_bin_morph_3x3_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_ERODE    = 2'b01,
    MODE_DILATE   = 2'b10,
    MODE_PASS_ALT = 2'b11
  } morph_mode_e;

  localparam int unsigned MORPH_LATENCY = 2;
  localparam int unsigned FG_COUNT_W    = 20;
  localparam int unsigned POS_W         = 10;

endpackage

// File: rtl/vip_frame_pos_cnt.sv
// Column/row position tracker for 3x3 window stages.
// Counts valid windows per line and lines per frame from the delayed sync signals
// and flags windows that sit on the image border.
// Ports:
//   clk, rstn    : pixel clock, asynchronous active-low reset
//   vsync        : frame valid (rising edge starts a frame)
//   href         : line valid (falling edge ends a line)
//   clken        : window valid strobe
//   frame_start  : vsync rising edge seen this cycle
//   border       : current window is on the first/last column or row (or a saturated count)
module vip_frame_pos_cnt
  import vip_bin_morph_3x3_pkg::*;
#(
  parameter logic [POS_W-1:0] IMG_HDISP = 10'd480,
  parameter logic [POS_W-1:0] IMG_VDISP = 10'd272
) (
  input  logic clk,
  input  logic rstn,
  input  logic vsync,
  input  logic href,
  input  logic clken,
  output logic frame_start,
  output logic border
);

  localparam logic [POS_W-1:0] ONE    = POS_W'(1);
  localparam logic [POS_W-1:0] H_LAST = IMG_HDISP - ONE;
  localparam logic [POS_W-1:0] V_LAST = IMG_VDISP - ONE;

  logic             vsync_q;
  logic             href_q;
  logic             href_fall;
  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] row_cur;

  assign frame_start = vsync & ~vsync_q;
  assign href_fall   = href_q & ~href;

  // A window arriving in the same cycle as the vsync rise already belongs to row 0.
  assign row_cur = frame_start ? '0 : row_q;

  assign border = (col_q == '0) | (col_q == H_LAST) | (row_cur == '0) | (row_cur == V_LAST);

  always_comb begin
    col_d = col_q;
    if (href_fall) begin
      col_d = '0;
    end else if (href && clken && (col_q != H_LAST)) begin
      col_d = col_q + ONE;
    end
  end

  // Frame start has priority over the line-end increment.
  always_comb begin
    row_d = row_q;
    if (frame_start) begin
      row_d = '0;
    end else if (href_fall && (row_q != V_LAST)) begin
      row_d = row_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // vsync history resets high so a reset released mid-frame is not mistaken for a new
      // frame; the mode stays at pass until a genuine vsync rise.
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/vip_bin_morph_3x3.sv
// 3x3 binary morphology stage: erosion, dilation or pass-through of the window centre,
// with border windows forced to BORDER_VAL. Two-clock latency, one window per clock.
// Optional feature macro: MORPH_FG_COUNT_EN adds a per-frame foreground pixel counter.
// Ports:
//   clk, rstn                    : pixel clock, asynchronous active-low reset
//   mode                         : 00 pass, 01 erode, 10 dilate, 11 pass (latched per frame)
//   matrix_frame_vsync/href/clken: syncs from the matrix generator
//   matrix_p11..matrix_p33       : 3x3 window, p22 is the centre
//   post_frame_vsync/href/clken  : syncs delayed by two clocks
//   post_img_bit                 : filtered pixel
//   fg_count, fg_count_valid     : last frame's foreground count and update pulse
//                                  (MORPH_FG_COUNT_EN only)
module vip_bin_morph_3x3
  import vip_bin_morph_3x3_pkg::*;
#(
  parameter logic [POS_W-1:0] IMG_HDISP  = 10'd480,
  parameter logic [POS_W-1:0] IMG_VDISP  = 10'd272,
  parameter logic             BORDER_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] mode,
  input  logic       matrix_frame_vsync,
  input  logic       matrix_frame_href,
  input  logic       matrix_frame_clken,
  input  logic       matrix_p11,
  input  logic       matrix_p12,
  input  logic       matrix_p13,
  input  logic       matrix_p21,
  input  logic       matrix_p22,
  input  logic       matrix_p23,
  input  logic       matrix_p31,
  input  logic       matrix_p32,
  input  logic       matrix_p33,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_bit
`ifdef MORPH_FG_COUNT_EN
  ,
  output logic [FG_COUNT_W-1:0] fg_count,
  output logic                  fg_count_valid
`endif
);

  logic        frame_start;
  logic        border;
  logic [8:0]  window;

  morph_mode_e active_mode_q;
  morph_mode_e s1_mode;
  logic        s1_border, s1_and, s1_or, s1_p22;
  logic        bit_d;

  logic [MORPH_LATENCY-1:0] vs_pipe, hr_pipe, ce_pipe;

  assign window = {matrix_p11, matrix_p12, matrix_p13,
                   matrix_p21, matrix_p22, matrix_p23,
                   matrix_p31, matrix_p32, matrix_p33};

  vip_frame_pos_cnt #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_pos_cnt (
    .clk         (clk),
    .rstn        (rstn),
    .vsync       (matrix_frame_vsync),
    .href        (matrix_frame_href),
    .clken       (matrix_frame_clken),
    .frame_start (frame_start),
    .border      (border)
  );

  // Stage 1: reductions, border flag and the mode that applies to this window. The mode
  // travels with the window so trailing windows of the previous frame keep the old mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_mode_q <= MODE_PASS;
      s1_mode       <= MODE_PASS;
      s1_border     <= 1'b0;
      s1_and        <= 1'b0;
      s1_or         <= 1'b0;
      s1_p22        <= 1'b0;
    end else begin
      if (frame_start) begin
        active_mode_q <= morph_mode_e'(mode);
      end
      s1_mode   <= frame_start ? morph_mode_e'(mode) : active_mode_q;
      s1_border <= border;
      s1_and    <= &window;
      s1_or     <= |window;
      s1_p22    <= matrix_p22;
    end
  end

  // Stage 2 select: blank outside lines, hold across clken gaps.
  always_comb begin
    bit_d = post_img_bit;
    if (!hr_pipe[0]) begin
      bit_d = 1'b0;
    end else if (ce_pipe[0]) begin
      if (s1_border) begin
        bit_d = BORDER_VAL;
      end else begin
        case (s1_mode)
          MODE_ERODE:  bit_d = s1_and;
          MODE_DILATE: bit_d = s1_or;
          default:     bit_d = s1_p22;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_pipe      <= '0;
      hr_pipe      <= '0;
      ce_pipe      <= '0;
      post_img_bit <= 1'b0;
    end else begin
      vs_pipe      <= {vs_pipe[MORPH_LATENCY-2:0], matrix_frame_vsync};
      hr_pipe      <= {hr_pipe[MORPH_LATENCY-2:0], matrix_frame_href};
      ce_pipe      <= {ce_pipe[MORPH_LATENCY-2:0], matrix_frame_clken};
      post_img_bit <= bit_d;
    end
  end

  assign post_frame_vsync = vs_pipe[MORPH_LATENCY-1];
  assign post_frame_href  = hr_pipe[MORPH_LATENCY-1];
  assign post_frame_clken = ce_pipe[MORPH_LATENCY-1];

`ifdef MORPH_FG_COUNT_EN
  localparam logic [FG_COUNT_W-1:0] FG_ONE = FG_COUNT_W'(1);

  logic                  post_vs_q;
  logic                  vs_fall;
  logic                  fg_inc;
  logic [FG_COUNT_W-1:0] fg_acc_q;
  logic [FG_COUNT_W-1:0] fg_sum;

  assign vs_fall = post_vs_q & ~post_frame_vsync;
  assign fg_inc  = post_frame_href & post_frame_clken & post_img_bit;

  // Saturating sum including this cycle, so a pixel on the vsync-fall cycle is counted.
  always_comb begin
    fg_sum = fg_acc_q;
    if (fg_inc && (fg_acc_q != '1)) begin
      fg_sum = fg_acc_q + FG_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      post_vs_q      <= 1'b0;
      fg_acc_q       <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
    end else begin
      post_vs_q      <= post_frame_vsync;
      fg_count_valid <= vs_fall;
      if (vs_fall) begin
        fg_count <= fg_sum;
        fg_acc_q <= '0;
      end else begin
        fg_acc_q <= fg_sum;
      end
    end
  end
`endif

endmodule
